// File: rtl/sound_pkg.sv
// Shared APU sound constants: IO register map, sample widths, frame-sequencer timing.
package sound_pkg;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 4;
  localparam int SUM_W    = 6;
  localparam int SAMPLE_W = 9;

  localparam logic [15:0] NR50_ADDR = 16'hFF24;
  localparam logic [15:0] NR51_ADDR = 16'hFF25;
  localparam logic [15:0] NR52_ADDR = 16'hFF26;

  localparam int CLOCKS256 = 128906;
  localparam int CLOCKS64  = 515625;

  typedef struct packed {
    logic       vin_l;
    logic [2:0] vol_l;
    logic       vin_r;
    logic [2:0] vol_r;
  } nr50_t;

  // Master volume is 1..8, so the product tops out at 60 * 8 = 480.
  function automatic logic [SAMPLE_W-1:0] scale(input logic [SUM_W-1:0] sum,
                                                input logic [2:0] vol);
    return {3'b0, sum} * ({6'b0, vol} + 9'd1);
  endfunction
endpackage

// File: rtl/sound_pwm_dac.sv
// One-bit PWM DAC side; duty is captured at the start of each period of the shared counter.
module sound_pwm_dac
  import sound_pkg::*;
#(
  parameter int PWM_MAX = 479
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic [SAMPLE_W-1:0] duty,
  input  logic [SAMPLE_W-1:0] cnt,
  output logic                pwm
);
  logic [SAMPLE_W-1:0] duty_q, duty_cur;

  // Counter==0 uses the fresh duty directly so the whole period sees one value.
  always_comb duty_cur = (cnt == '0) ? duty : duty_q;

  always_ff @(posedge clk) begin
    if (!reset_l)        duty_q <= '0;
    else if (cnt == '0)  duty_q <= duty;
  end

  assign pwm = (cnt <= SAMPLE_W'(PWM_MAX)) && (cnt < duty_cur);
endmodule

// File: rtl/sound_mixer.sv
// APU mixer: NR50/51/52 registers, sample-rate routing + master volume, shared-counter PWM DACs.
// Optional SOUND_MIXER_CH_MUTE_EN adds a per-channel debug mute input.
module sound_mixer
  import sound_pkg::*;
#(
  parameter int SAMPLE_DIV = 750,
  parameter int PWM_MAX    = 479
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic [15:0]         ioreg_addr,
  inout  wire  [7:0]          ioreg_data,
  input  logic                ioreg_we_l,
  input  logic                ioreg_re_l,
  input  logic [CH_W-1:0]     ch1_sample,
  input  logic [CH_W-1:0]     ch2_sample,
  input  logic [CH_W-1:0]     ch3_sample,
  input  logic [CH_W-1:0]     ch4_sample,
  input  logic [NUM_CH-1:0]   ch_active,
`ifdef SOUND_MIXER_CH_MUTE_EN
  input  logic [NUM_CH-1:0]   ch_mute,
`endif
  output logic                sound_en,
  output logic [SAMPLE_W-1:0] left_sample,
  output logic [SAMPLE_W-1:0] right_sample,
  output logic                sample_valid,
  output logic                pwm_l,
  output logic                pwm_r
);
  localparam int STAGES = 2;

  nr50_t                      nr50;
  logic [7:0]                 nr51;
  logic                       enable;
  logic [15:0]                div_cnt;
  logic                       tick;
  logic [STAGES:1]            vld_pipe;
  logic [NUM_CH-1:0][CH_W-1:0] ch;
  logic [NUM_CH-1:0]          mute_mask;
  logic [SUM_W-1:0]           sum_l_d, sum_r_d, sum_l, sum_r;
  logic [SAMPLE_W-1:0]        pwm_cnt;
  logic                       rd_hit;
  logic [7:0]                 rd_val;

  assign ch       = {ch4_sample, ch3_sample, ch2_sample, ch1_sample};
  assign sound_en = enable;

`ifdef SOUND_MIXER_CH_MUTE_EN
  assign mute_mask = ~ch_mute;
`else
  assign mute_mask = '1;
`endif

  // Register file; NR50/NR51 are frozen while the APU is off.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      nr50   <= '0;
      nr51   <= '0;
      enable <= 1'b0;
    end else if (!ioreg_we_l) begin
      if (ioreg_addr == NR52_ADDR) begin
        enable <= ioreg_data[7];
        if (!ioreg_data[7]) begin
          nr50 <= '0;
          nr51 <= '0;
        end
      end else if (enable && ioreg_addr == NR50_ADDR) begin
        nr50 <= nr50_t'(ioreg_data);
      end else if (enable && ioreg_addr == NR51_ADDR) begin
        nr51 <= ioreg_data;
      end
    end
  end

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    if (!ioreg_re_l) begin
      case (ioreg_addr)
        NR50_ADDR: begin rd_hit = 1'b1; rd_val = nr50;                           end
        NR51_ADDR: begin rd_hit = 1'b1; rd_val = nr51;                           end
        NR52_ADDR: begin rd_hit = 1'b1; rd_val = {enable, 3'b111, ch_active};    end
        default:   ;
      endcase
    end
  end

  assign ioreg_data = rd_hit ? rd_val : 8'hzz;

  assign tick = (div_cnt == 16'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_l) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + 16'd1;
  end

  always_comb begin
    sum_l_d = '0;
    sum_r_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (enable && mute_mask[n] && nr51[n+4]) sum_l_d = sum_l_d + {2'b0, ch[n]};
      if (enable && mute_mask[n] && nr51[n])   sum_r_d = sum_r_d + {2'b0, ch[n]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      vld_pipe     <= '0;
      sum_l        <= '0;
      sum_r        <= '0;
      left_sample  <= '0;
      right_sample <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], tick};
      if (tick) begin
        sum_l <= sum_l_d;
        sum_r <= sum_r_d;
      end
      if (vld_pipe[1]) begin
        left_sample  <= scale(sum_l, nr50.vol_l);
        right_sample <= scale(sum_r, nr50.vol_r);
      end
    end
  end

  assign sample_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!reset_l) pwm_cnt <= '0;
    else          pwm_cnt <= (pwm_cnt == SAMPLE_W'(PWM_MAX)) ? '0 : pwm_cnt + 1'b1;
  end

  // Both sides share the one period counter so their periods stay aligned.
  sound_pwm_dac #(.PWM_MAX(PWM_MAX)) u_dac [1:0] (
    .clk     (clk),
    .reset_l (reset_l),
    .duty    ({right_sample, left_sample}),
    .cnt     (pwm_cnt),
    .pwm     ({pwm_r, pwm_l})
  );
endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer with a short sample divider.
module tb_sound_mixer;
  localparam int SD = 20;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [15:0] addr = '0;
  logic        we_l = 1'b1, re_l = 1'b1;
  logic [3:0]  c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic [3:0]  active = 4'b1010;
  logic [7:0]  drv = '0;
  logic        drv_en = 1'b0;
  wire  [7:0]  ioreg_data;
  logic        sound_en, sample_valid, pwm_l, pwm_r;
  logic [8:0]  left_sample, right_sample;

  int checks = 0, errors = 0;
  logic [7:0] rv;
  int hl, hr, n;

  assign ioreg_data = drv_en ? drv : 8'hzz;

  sound_mixer #(.SAMPLE_DIV(SD), .PWM_MAX(479)) dut (
    .clk(clk), .reset_l(reset_l), .ioreg_addr(addr), .ioreg_data(ioreg_data),
    .ioreg_we_l(we_l), .ioreg_re_l(re_l),
    .ch1_sample(c1), .ch2_sample(c2), .ch3_sample(c3), .ch4_sample(c4),
    .ch_active(active), .sound_en(sound_en), .left_sample(left_sample),
    .right_sample(right_sample), .sample_valid(sample_valid), .pwm_l(pwm_l), .pwm_r(pwm_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; drv = d; drv_en = 1'b1; we_l = 1'b0;
    step(1);
    we_l = 1'b1; drv_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr = a; re_l = 1'b0;
    #1 d = ioreg_data;
    re_l = 1'b1;
  endtask

  task automatic wait_valid();
    int k = 0;
    do begin step(1); k++; end while (!sample_valid && k < 3*SD);
    if (!sample_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic pwm_count(output int l, output int r);
    l = 0; r = 0;
    repeat (480) begin
      if (pwm_l) l++;
      if (pwm_r) r++;
      step(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    step(3);
    check("rst_en", sound_en, 0);
    check("rst_left", left_sample, 0);
    check("rst_right", right_sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_pwm_l", pwm_l, 0);
    check("rst_pwm_r", pwm_r, 0);
    rd(16'hFF24, rv); check("rst_nr50", rv, 8'h00);
    rd(16'hFF25, rv); check("rst_nr51", rv, 8'h00);
    rd(16'hFF26, rv); check("rst_nr52", rv, 8'h7A);
    reset_l = 1'b1;
    step(1);
    wr(16'hFF25, 8'hFF);
    rd(16'hFF25, rv); check("off_nr51_ignored", rv, 8'h00);

    // full scale
    c1 = 15; c2 = 15; c3 = 15; c4 = 15;
    wr(16'hFF26, 8'h80); wr(16'hFF25, 8'hFF); wr(16'hFF24, 8'h77);
    check("en_on", sound_en, 1);
    rd(16'hFF26, rv); check("nr52_on", rv, 8'hFA);
    wait_valid(); wait_valid();
    check("full_left", left_sample, 480);
    check("full_right", right_sample, 480);
    step(1);
    check("valid_pulse", sample_valid, 0);
    step(500);
    pwm_count(hl, hr);
    check("full_pwm_l", hl, 480);
    check("full_pwm_r", hr, 480);

    // one channel, asymmetric volume
    c1 = 5; c2 = 0; c3 = 0; c4 = 0;
    wr(16'hFF25, 8'h11); wr(16'hFF24, 8'h30);
    wait_valid(); wait_valid();
    check("ch1_left", left_sample, 20);
    check("ch1_right", right_sample, 5);
    rd(16'hFF24, rv); check("rb_nr50", rv, 8'h30);
    rd(16'hFF25, rv); check("rb_nr51", rv, 8'h11);
    step(500);
    pwm_count(hl, hr);
    check("ch1_pwm_l", hl, 20);
    check("ch1_pwm_r", hr, 5);

    // power off while playing
    wr(16'hFF26, 8'h00);
    check("en_off", sound_en, 0);
    rd(16'hFF24, rv); check("off_nr50", rv, 8'h00);
    rd(16'hFF25, rv); check("off_nr51", rv, 8'h00);
    rd(16'hFF26, rv); check("off_nr52", rv, 8'h7A);
    wr(16'hFF25, 8'hFF);
    rd(16'hFF25, rv); check("off_wr_ignored", rv, 8'h00);
    wait_valid(); wait_valid();
    check("off_left", left_sample, 0);
    check("off_right", right_sample, 0);

    // routing change written in the tick cycle
    wr(16'hFF26, 8'h80); wr(16'hFF24, 8'h88);
    c1 = 5; c2 = 3;
    wr(16'hFF25, 8'h11);
    rd(16'hFF24, rv); check("vin_readback", rv, 8'h88);
    wait_valid(); wait_valid();
    check("pre_left", left_sample, 5);
    step(SD-2);
    wr(16'hFF25, 8'h22);
    wait_valid();
    check("tick_old_left", left_sample, 5);
    check("tick_old_right", right_sample, 5);
    wait_valid();
    check("tick_new_left", left_sample, 3);
    check("tick_new_right", right_sample, 3);

    // half duty, then reset mid-period
    c1 = 15; c2 = 15;
    wr(16'hFF25, 8'h30); wr(16'hFF24, 8'h70);
    wait_valid(); wait_valid();
    check("half_left", left_sample, 240);
    check("half_right", right_sample, 0);
    step(500);
    pwm_count(hl, hr);
    check("half_pwm_l", hl, 240);
    check("half_pwm_r", hr, 0);
    step(100);
    reset_l = 1'b0;
    step(1);
    check("mid_rst_pwm_l", pwm_l, 0);
    check("mid_rst_left", left_sample, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_en", sound_en, 0);
    rd(16'hFF25, rv); check("mid_rst_nr51", rv, 8'h00);
    reset_l = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!sample_valid && n < 3*SD);
    check("first_valid_lat", n, SD+1);
    n = 0;
    do begin step(1); n++; end while (!sample_valid && n < 3*SD);
    check("valid_spacing", n, SD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
